// File: rtl/acc_output_buffer.sv
// Output buffer behind the accumulator: captures finished results into a small register file
// and drains a wrap-around address range to the host over a valid/ready stream.
module acc_output_buffer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              drain_start,
  input  logic [ADDR_W-1:0] drain_base,
  input  logic [ADDR_W:0]   drain_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic [DEPTH-1:0]  entry_valid,
  output logic              overwrite_err,
  output logic              underrun_err,
  input  logic              err_clear
);

  typedef enum logic [1:0] {StIdle, StFetch, StPresent, StDone} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [ADDR_W:0]     remaining_q;
  logic [ADDR_W:0]     len_clamped;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]    entry_valid_q, entry_valid_d;
  logic                handshake, wr_hit, underrun_hit;

  assign handshake = (state_q == StPresent) && out_ready;

  // A write landing on the entry being released by this handshake is not an overwrite.
  assign wr_hit       = wr_en && entry_valid_q[wr_addr] && !(handshake && (wr_addr == ptr_q));
  assign underrun_hit = (state_q == StFetch) && !entry_valid_q[ptr_q];

  assign len_clamped = (drain_len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : drain_len;

  always_comb begin
    entry_valid_d = entry_valid_q;
    if (handshake) entry_valid_d[ptr_q] = 1'b0;
    if (wr_en)     entry_valid_d[wr_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_valid_q <= '0;
      overwrite_err <= 1'b0;
      underrun_err  <= 1'b0;
    end else begin
      entry_valid_q <= entry_valid_d;
      overwrite_err <= (overwrite_err && !err_clear) || wr_hit;
      underrun_err  <= (underrun_err && !err_clear) || underrun_hit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      remaining_q <= '0;
      out_data    <= '0;
      out_addr    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (drain_start && (drain_len != '0)) begin
            ptr_q       <= drain_base;
            remaining_q <= len_clamped;
            state_q     <= StFetch;
          end
        end
        StFetch: begin
          out_data <= mem[ptr_q];
          out_addr <= ptr_q;
          state_q  <= StPresent;
        end
        StPresent: begin
          if (out_ready) begin
            ptr_q       <= ptr_q + ADDR_W'(1);
            remaining_q <= remaining_q - (ADDR_W+1)'(1);
            state_q     <= (remaining_q == (ADDR_W+1)'(1)) ? StDone : StFetch;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_valid   = (state_q == StPresent);
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign entry_valid = entry_valid_q;

endmodule

// File: tb/tb_acc_output_buffer.sv
// Directed bench for acc_output_buffer: hand-computed expectations checked with immediate asserts.
module tb_acc_output_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        drain_start;
  logic [3:0]  drain_base;
  logic [4:0]  drain_len;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_addr;
  logic        busy;
  logic        done;
  logic [15:0] entry_valid;
  logic        overwrite_err;
  logic        underrun_err;
  logic        err_clear;

  int n_checks = 0;
  int n_fail   = 0;

  acc_output_buffer #(.DEPTH(16), .ADDR_W(4), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .drain_start  (drain_start),
    .drain_base   (drain_base),
    .drain_len    (drain_len),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_addr     (out_addr),
    .busy         (busy),
    .done         (done),
    .entry_valid  (entry_valid),
    .overwrite_err(overwrite_err),
    .underrun_err (underrun_err),
    .err_clear    (err_clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start(input logic [3:0] base, input logic [4:0] len);
    drain_start = 1'b1; drain_base = base; drain_len = len;
    tick();
    drain_start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    check(tag, {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; drain_start = 1'b0;
    drain_base = '0; drain_len = '0; out_ready = 1'b0; err_clear = 1'b0;
    tick(); tick();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_ev",    {16'd0, entry_valid}, 32'd0);
    check("rst_errs",  {30'd0, overwrite_err, underrun_err}, 32'd0);
    check("rst_data",  out_data, 32'd0);
    rst = 1'b1;
    tick();

    // Single-entry drain
    write(4'd3, 32'h3F80_0000);
    check("t1_ev", {16'd0, entry_valid}, 32'h0000_0008);
    start(4'd3, 5'd1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_nv",   {31'd0, out_valid}, 32'd0);
    tick();
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_data",  out_data, 32'h3F80_0000);
    check("t1_addr",  {28'd0, out_addr}, 32'd3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_busyd", {31'd0, busy}, 32'd1);
    check("t1_ev0",  {16'd0, entry_valid}, 32'd0);
    tick();
    check("t1_done0", {31'd0, done}, 32'd0);
    check("t1_idle",  {31'd0, busy}, 32'd0);

    // Wrap-around drain with stalls
    write(4'd14, 32'hA); write(4'd15, 32'hB); write(4'd0, 32'hC); write(4'd1, 32'hD);
    check("t2_ev", {16'd0, entry_valid}, 32'h0000_C003);
    start(4'd14, 5'd4);
    for (int i = 0; i < 4; i++) begin
      wait_valid("t2_wait");
      check("t2_addr", {28'd0, out_addr}, 32'((14 + i) % 16));
      check("t2_data", out_data, 32'hA + 32'(i));
      tick();
      check("t2_hold_v", {31'd0, out_valid}, 32'd1);
      check("t2_hold_d", out_data, 32'hA + 32'(i));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      if (i < 3) check("t2_bubble", {31'd0, out_valid}, 32'd0);
    end
    check("t2_done", {31'd0, done}, 32'd1);
    tick();
    check("t2_ev0", {16'd0, entry_valid}, 32'd0);
    check("t2_idle", {31'd0, busy}, 32'd0);

    // Overwrite error, clear, and set-wins
    write(4'd5, 32'h11);
    check("t3_ok", {31'd0, overwrite_err}, 32'd0);
    write(4'd5, 32'h22);
    check("t3_ow", {31'd0, overwrite_err}, 32'd1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("t3_clr", {31'd0, overwrite_err}, 32'd0);
    err_clear = 1'b1;
    write(4'd5, 32'h55);
    err_clear = 1'b0;
    check("t3_setwins", {31'd0, overwrite_err}, 32'd1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;

    // Underrun on never-written entry
    start(4'd8, 5'd1);
    tick();
    check("t4_valid", {31'd0, out_valid}, 32'd1);
    check("t4_addr",  {28'd0, out_addr}, 32'd8);
    check("t4_ur",    {31'd0, underrun_err}, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    check("t4_idle", {31'd0, busy}, 32'd0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("t4_clr", {31'd0, underrun_err}, 32'd0);

    // Write racing the handshake on the same entry
    write(4'd2, 32'hCAFE_F00D);
    start(4'd2, 5'd1);
    tick();
    check("t5_data", out_data, 32'hCAFE_F00D);
    out_ready = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h1234_5678;
    tick();
    out_ready = 1'b0; wr_en = 1'b0;
    check("t5_old",  out_data, 32'hCAFE_F00D);
    check("t5_ev",   {16'd0, entry_valid}, 32'h0000_0024);
    check("t5_noow", {31'd0, overwrite_err}, 32'd0);
    tick();
    start(4'd2, 5'd1);
    tick();
    check("t5_new", out_data, 32'h1234_5678);
    check("t5_nour", {31'd0, underrun_err}, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();

    // Ignored commands: zero length and start while busy
    start(4'd5, 5'd0);
    check("t6_len0", {31'd0, busy}, 32'd0);
    tick();
    check("t6_nodone", {31'd0, done}, 32'd0);
    start(4'd5, 5'd1);
    start(4'd0, 5'd3);
    check("t6_addr", {28'd0, out_addr}, 32'd5);
    check("t6_data", out_data, 32'h55);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t6_done", {31'd0, done}, 32'd1);
    tick(); tick();
    check("t6_idle", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-drain
    write(4'd4, 32'h77);
    start(4'd4, 5'd1);
    tick();
    check("t7_valid", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t7_valid0", {31'd0, out_valid}, 32'd0);
    check("t7_busy0",  {31'd0, busy}, 32'd0);
    check("t7_ev0",    {16'd0, entry_valid}, 32'd0);
    check("t7_data0",  out_data, 32'd0);
    check("t7_addr0",  {28'd0, out_addr}, 32'd0);
    tick();
    check("t7_nodone", {31'd0, done}, 32'd0);
    rst = 1'b1;
    tick();
    check("t7_idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
